// File: rtl/daisychain_master_if.sv
// Host-side request/response bundle for the daisychain serial master.
// Handshake: the host raises start for a cycle with cmd/wr_data valid; the
// master accepts it only while busy is 0 (IDLE) and ignores it otherwise.
// Completion is a single-cycle done pulse (rd_valid alongside it for reads),
// with no back-pressure from the host side.
interface daisychain_master_if #(
    parameter int CMD_LEN  = 2,
    parameter int DATA_LEN = 8
);
    logic                start;
    logic [CMD_LEN-1:0]  cmd;
    logic [DATA_LEN-1:0] wr_data;
    logic                busy;
    logic                done;
    logic [DATA_LEN-1:0] rd_data;
    logic                rd_valid;
    // Observability: registered line output enable and FSM state.
    logic                line_oe;
    logic [3:0]          state_dbg;

    modport master (
        input  start, cmd, wr_data,
        output busy, done, rd_data, rd_valid, line_oe, state_dbg
    );

    modport slave (
        output start, cmd, wr_data,
        input  busy, done, rd_data, rd_valid, line_oe, state_dbg
    );
endinterface

// File: rtl/daisychain_master.sv
// Daisychain bus master: serialises host commands into start bit, command,
// gap and data phase; for reads it releases the line and captures the word
// shifted back by the chain. Line is driven low whenever the master is idle.
module daisychain_master #(
    parameter int DATA_LEN  = 8,
    parameter int CMD_LEN   = 2,
    parameter int GAP_CYC   = 2,
    parameter int RD_LAT    = 2,
    parameter int GUARD_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    inout  wire                    data_inout,
    daisychain_master_if.master    bus
);
    localparam int CW = $clog2(DATA_LEN + GAP_CYC + RD_LAT + GUARD_CYC + 1);
    localparam logic [CMD_LEN-1:0] CMD_WRITE = CMD_LEN'(2);
    localparam logic [CMD_LEN-1:0] CMD_READ  = CMD_LEN'(3);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START    = 4'd1,
        S_CMD      = 4'd2,
        S_GAP      = 4'd3,
        S_WR       = 4'd4,
        S_RD_WAIT  = 4'd5,
        S_RD       = 4'd6,
        S_RD_GUARD = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t              state;
    state_t              nxt;
    state_t              upc;
    logic                adv;
    logic [CW-1:0]       cnt;
    logic [CMD_LEN-1:0]  cmd_q;
    logic [CMD_LEN-1:0]  cmd_sh;
    logic [DATA_LEN-1:0] wr_sh;
    logic [DATA_LEN-1:0] cap;
    logic [DATA_LEN-1:0] cap_nxt;
    logic [DATA_LEN:0]   cap_ext;
    logic                line_oe;
    logic                line_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_valid_q;
    logic [DATA_LEN-1:0] rd_data_q;

    // Where a frame goes after the gap; zero-length phases are skipped.
    function automatic state_t after_gap(input logic [CMD_LEN-1:0] c);
        if (c == CMD_WRITE) return S_WR;
        if (c == CMD_READ)  return (RD_LAT > 0) ? S_RD_WAIT : S_RD;
        return S_DONE;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [CMD_LEN-1:0] c);
        case (s)
            S_IDLE:     return S_START;
            S_START:    return S_CMD;
            S_CMD:      return (GAP_CYC > 0) ? S_GAP : after_gap(c);
            S_GAP:      return after_gap(c);
            S_WR:       return S_DONE;
            S_RD_WAIT:  return S_RD;
            S_RD:       return (GUARD_CYC > 0) ? S_RD_GUARD : S_DONE;
            S_RD_GUARD: return S_DONE;
            default:    return S_IDLE;
        endcase
    endfunction

    // Counter preload on state entry: phase length minus one.
    function automatic logic [CW-1:0] len_m1(input state_t s);
        int n;
        case (s)
            S_CMD:      n = CMD_LEN;
            S_GAP:      n = GAP_CYC;
            S_WR:       n = DATA_LEN;
            S_RD_WAIT:  n = RD_LAT;
            S_RD:       n = DATA_LEN;
            S_RD_GUARD: n = GUARD_CYC;
            default:    n = 1;
        endcase
        return CW'(n - 1);
    endfunction

    // Next-state decode and the capture shift (first sampled bit ends up MSB).
    always_comb begin
        adv     = (state == S_IDLE) ? bus.start : (cnt == '0);
        nxt     = next_of(state, cmd_q);
        upc     = adv ? nxt : state;
        cap_ext = {cap, data_inout};
        cap_nxt = (state == S_RD) ? cap_ext[DATA_LEN-1:0] : cap;
    end

    // FSM, down-counter and registered line/handshake outputs for the upcoming cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cmd_q      <= '0;
            cmd_sh     <= '0;
            wr_sh      <= '0;
            cap        <= '0;
            line_oe    <= 1'b1;
            line_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cap <= cap_nxt;
            if (state == S_IDLE && bus.start) begin
                cmd_q  <= bus.cmd;
                cmd_sh <= bus.cmd;
                wr_sh  <= bus.wr_data;
            end
            if (adv) begin
                state <= nxt;
                cnt   <= len_m1(nxt);
            end else if (state != S_IDLE) begin
                cnt <= cnt - CW'(1);
            end

            line_oe <= !(upc == S_RD_WAIT || upc == S_RD || upc == S_RD_GUARD);
            case (upc)
                S_START: line_q <= 1'b1;
                S_CMD: begin
                    line_q <= cmd_sh[CMD_LEN-1];
                    cmd_sh <= cmd_sh << 1;
                end
                S_WR: begin
                    line_q <= wr_sh[DATA_LEN-1];
                    wr_sh  <= wr_sh << 1;
                end
                default: line_q <= 1'b0;
            endcase

            busy_q     <= (upc != S_IDLE);
            done_q     <= (upc == S_DONE);
            rd_valid_q <= (upc == S_DONE) && (cmd_q == CMD_READ);
            if (upc == S_DONE && cmd_q == CMD_READ) begin
                rd_data_q <= cap_nxt;
            end
        end
    end

    assign data_inout    = line_oe ? line_q : 1'bz;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.line_oe   = line_oe;
    assign bus.state_dbg = state;
endmodule
